// File: rtl/eth_gmii_rx.sv
// GMII RX parser: strips preamble/SFD, filters dst MAC / IPv4 / UDP, streams the UDP payload two cycles behind gmii_rx.
// Optional ETH_RX_FCS_CHECK_EN: CRC-32 FCS check, payload buffered so the final pl_eof waits for the verdict.

`ifdef ETH_RX_FCS_CHECK_EN
module eth_gmii_rx_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2048
) (
    input  logic         clk_125m,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   used;
    logic          do_push, do_pop;

    assign empty   = (used == '0);
    assign do_push = push && (used != (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_125m) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            used <= used + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule
`endif

module eth_gmii_rx #(
    parameter logic [47:0] LOCAL_MAC   = 48'h00_11_22_33_44_56,
    parameter int          MAX_PAYLOAD = 1472,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_125m,
    input  logic             rst_n,
    input  logic [7:0]       gmii_rx,
    input  logic             gmii_rxv,
    input  logic             gmii_rxer,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pl_sof,
    output logic             pl_eof,
    output logic [15:0]      pl_len,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_drop_cnt
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [7:0]  rx_dat;
    logic        rx_vld, rx_er;
    logic [15:0] cnt, cnt_nx;
    logic        uc_ok, uc_ok_nx, bc_ok, bc_ok_nx;
    logic [7:0]  len_hi, len_hi_nx;
    logic [15:0] pl_len_nx, udp_len;
    logic        par_vld, par_sof, par_eof;
    logic [7:0]  par_dat;
    logic        frame_good, frame_bad, hdr_fail;
    logic        ok_inc, drop_inc;

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        logic [47:0] sh;
        sh = LOCAL_MAC >> (6'd40 - 6'(idx) * 6'd8);
        return sh[7:0];
    endfunction

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        uc_ok_nx   = uc_ok;
        bc_ok_nx   = bc_ok;
        len_hi_nx  = len_hi;
        pl_len_nx  = pl_len;
        par_vld    = 1'b0;
        par_sof    = 1'b0;
        par_eof    = 1'b0;
        par_dat    = 8'h00;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        hdr_fail   = 1'b0;
        udp_len    = {len_hi, rx_dat};
        case (state)
            IDLE: if (rx_vld) begin
                cnt_nx = 16'd1;
                if (rx_dat == 8'h55) begin
                    state_nx = PREAMBLE;
                end else begin
                    state_nx  = DRAIN;
                    frame_bad = 1'b1;
                end
            end
            DRAIN: if (!rx_vld) state_nx = IDLE;
            default: if (!rx_vld || rx_er) begin
                // A falling rxv goes straight to IDLE so the next frame may follow after one idle cycle
                state_nx  = rx_vld ? DRAIN : IDLE;
                frame_bad = 1'b1;
                if (state == PAYLOAD) begin
                    par_vld = 1'b1;
                    par_eof = 1'b1;
                end
            end else begin
                cnt_nx = cnt + 16'd1;
                case (state)
                    PREAMBLE: begin
                        if (rx_dat == 8'hD5) begin
                            state_nx = ETH_HDR;
                            cnt_nx   = '0;
                        end else if (rx_dat != 8'h55 || cnt == 16'd7) begin
                            hdr_fail = 1'b1;
                        end
                    end
                    ETH_HDR: begin
                        if (cnt < 16'd6) begin
                            uc_ok_nx = (cnt == 16'd0 || uc_ok) && (rx_dat == mac_byte(cnt[2:0]));
                            bc_ok_nx = (cnt == 16'd0 || bc_ok) && (rx_dat == 8'hFF);
                            hdr_fail = !uc_ok_nx && !bc_ok_nx;
                        end
                        if (cnt == 16'd12 && rx_dat != 8'h08) hdr_fail = 1'b1;
                        if (cnt == 16'd13) begin
                            hdr_fail = (rx_dat != 8'h00);
                            state_nx = IP_HDR;
                            cnt_nx   = '0;
                        end
                    end
                    IP_HDR: begin
                        if (cnt == 16'd0 && rx_dat != 8'h45) hdr_fail = 1'b1;
                        if (cnt == 16'd9 && rx_dat != 8'h11) hdr_fail = 1'b1;
                        if (cnt == 16'd19) begin
                            state_nx = UDP_HDR;
                            cnt_nx   = '0;
                        end
                    end
                    UDP_HDR: begin
                        if (cnt == 16'd4) len_hi_nx = rx_dat;
                        if (cnt == 16'd5) begin
                            if (udp_len < 16'd8 || udp_len > 16'(MAX_PAYLOAD + 8)) hdr_fail = 1'b1;
                            else pl_len_nx = udp_len - 16'd8;
                        end
                        if (cnt == 16'd7) begin
                            cnt_nx = '0;
                            if (pl_len == 16'd0) begin
                                frame_good = 1'b1;
                                state_nx   = DRAIN;
                            end else begin
                                state_nx = PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        par_vld = 1'b1;
                        par_dat = rx_dat;
                        par_sof = (cnt == 16'd0);
                        par_eof = (cnt == pl_len - 16'd1);
                        if (par_eof) begin
                            frame_good = 1'b1;
                            state_nx   = DRAIN;
                        end
                    end
                    default: ;
                endcase
                if (hdr_fail) begin
                    state_nx  = DRAIN;
                    frame_bad = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            rx_dat         <= '0;
            rx_vld         <= 1'b0;
            rx_er          <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            uc_ok          <= 1'b0;
            bc_ok          <= 1'b0;
            len_hi         <= '0;
            pl_len         <= '0;
            frame_ok_cnt   <= '0;
            frame_drop_cnt <= '0;
        end else begin
            rx_dat <= gmii_rx;
            rx_vld <= gmii_rxv;
            rx_er  <= gmii_rxer;
            state  <= state_nx;
            cnt    <= cnt_nx;
            uc_ok  <= uc_ok_nx;
            bc_ok  <= bc_ok_nx;
            len_hi <= len_hi_nx;
            pl_len <= pl_len_nx;
            if (ok_inc && frame_ok_cnt != '1)     frame_ok_cnt   <= frame_ok_cnt + CNT_W'(1);
            if (drop_inc && frame_drop_cnt != '1) frame_drop_cnt <= frame_drop_cnt + CNT_W'(1);
        end
    end

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic        crc_run, ok_pend, pl_pend, vrd_vld, vrd_good;
    logic        fcs_done, fcs_good;
    logic [10:0] fifo_head;
    logic        fifo_empty, fifo_pop, head_err, head_sof, head_eof;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    assign fcs_done = crc_run && !rx_vld;
    assign fcs_good = (bit_rev(crc) == 32'hC704DD7B);
    assign ok_inc   = fcs_done && ok_pend && fcs_good;
    assign drop_inc = frame_bad || (fcs_done && ok_pend && !fcs_good);
    assign {head_err, head_sof, head_eof} = fifo_head[10:8];
    // Last payload byte of a good frame parks at the FIFO head until the FCS verdict arrives
    assign fifo_pop = !fifo_empty && (!head_eof || head_err || vrd_vld);

    eth_gmii_rx_fifo #(.W(11), .DEPTH(2048)) u_fifo (
        .clk_125m (clk_125m),
        .rst_n    (rst_n),
        .push     (par_vld),
        .push_dat ({frame_bad, par_sof, par_eof, par_dat}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            crc      <= '1;
            crc_run  <= 1'b0;
            ok_pend  <= 1'b0;
            pl_pend  <= 1'b0;
            vrd_vld  <= 1'b0;
            vrd_good <= 1'b0;
            pl_valid <= 1'b0;
            pl_sof   <= 1'b0;
            pl_eof   <= 1'b0;
            pl_data  <= '0;
        end else begin
            if (state == PREAMBLE && state_nx == ETH_HDR) begin
                crc     <= '1;
                crc_run <= 1'b1;
                ok_pend <= 1'b0;
                pl_pend <= 1'b0;
            end else if (crc_run && rx_vld) begin
                crc <= crc_byte(crc, rx_dat);
            end
            if (frame_good) begin
                ok_pend <= 1'b1;
                pl_pend <= (state == PAYLOAD);
            end
            if (fcs_done) begin
                crc_run <= 1'b0;
                ok_pend <= 1'b0;
                pl_pend <= 1'b0;
                if (ok_pend && pl_pend) begin
                    vrd_vld  <= 1'b1;
                    vrd_good <= fcs_good;
                end
            end
            if (fifo_pop && head_eof && !head_err) vrd_vld <= 1'b0;
            pl_valid <= fifo_pop;
            pl_sof   <= fifo_pop && head_sof;
            pl_eof   <= fifo_pop && head_eof;
            // A failed FCS turns the held last byte into the zero-data error marker
            pl_data  <= (fifo_pop && !(head_eof && (head_err || !vrd_good))) ? fifo_head[7:0] : 8'h00;
        end
    end
`else
    assign ok_inc   = frame_good;
    assign drop_inc = frame_bad;

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            pl_valid <= 1'b0;
            pl_sof   <= 1'b0;
            pl_eof   <= 1'b0;
            pl_data  <= '0;
        end else begin
            pl_valid <= par_vld;
            pl_sof   <= par_sof;
            pl_eof   <= par_eof;
            pl_data  <= par_dat;
        end
    end
`endif

endmodule

// File: tb/tb_eth_gmii_rx.sv
// Scoreboard bench for eth_gmii_rx: frames are built here, expected payload beats queued as each frame is driven.
module tb_eth_gmii_rx;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gmii_rx = 8'h00;
    logic        gmii_rxv = 1'b0;
    logic        gmii_rxer = 1'b0;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_sof, pl_eof;
    logic [15:0] pl_len;
    logic [15:0] frame_ok_cnt, frame_drop_cnt;

    typedef struct packed {
        logic [7:0] dat;
        logic       sof;
        logic       eof;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  frm[$];
    logic [47:0] mac_local = 48'h00_11_22_33_44_56;
    int          checks = 0;
    int          failures = 0;
    int          ok_exp = 0;
    int          drop_exp = 0;

    always #4 clk_125m = ~clk_125m;

    eth_gmii_rx dut (
        .clk_125m       (clk_125m),
        .rst_n          (rst_n),
        .gmii_rx        (gmii_rx),
        .gmii_rxv       (gmii_rxv),
        .gmii_rxer      (gmii_rxer),
        .pl_data        (pl_data),
        .pl_valid       (pl_valid),
        .pl_sof         (pl_sof),
        .pl_eof         (pl_eof),
        .pl_len         (pl_len),
        .frame_ok_cnt   (frame_ok_cnt),
        .frame_drop_cnt (frame_drop_cnt)
    );

    function automatic logic [7:0] pay_byte(input int i);
        case (i)
            0:       return 8'h16;
            1:       return 8'hBF;
            2:       return 8'hEF;
            21:      return 8'h9C;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    // One clock: drive inputs, then on the falling edge pop and compare any payload beat.
    task automatic step(input logic [7:0] d, input logic v, input logic e);
        beat_t got, want;
        gmii_rx = d;
        gmii_rxv = v;
        gmii_rxer = e;
        @(posedge clk_125m);
        @(negedge clk_125m);
        if (pl_valid === 1'b1) begin
            got = {pl_data, pl_sof, pl_eof};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got data=%02h sof=%0b eof=%0b, required no beat",
                         got.dat, got.sof, got.eof);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL beat: got data=%02h sof=%0b eof=%0b, required data=%02h sof=%0b eof=%0b",
                             got.dat, got.sof, got.eof, want.dat, want.sof, want.eof);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic make_frame(input int n_pre, input logic [47:0] dst, input logic [15:0] etype,
                              input logic [7:0] proto, input logic [15:0] udp_len);
        logic [31:0] crc;
        logic [7:0]  hdr [28];
        hdr = '{8'h45, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, proto,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02,
                8'h04, 8'hD2, 8'h16, 8'h2E, udp_len[15:8], udp_len[7:0], 8'h00, 8'h00};
        frm.delete();
        for (int i = 0; i < n_pre; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(mac_local[i*8 +: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < 28; i++) frm.push_back(hdr[i]);
        for (int i = 0; i < 22; i++) frm.push_back(pay_byte(i));
        crc = 32'hFFFF_FFFF;
        for (int i = n_pre + 1; i < frm.size(); i++) begin
            crc ^= {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) frm.push_back(crc[k*8 +: 8]);
    endtask

    task automatic expect_payload(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = {pay_byte(i), i == 0, i == n - 1};
            exp_q.push_back(b);
        end
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) step(frm[i], 1'b1, 1'b0);
    endtask

    task automatic check_state(input string name, input logic [15:0] len_exp);
        checks++;
        if ({frame_ok_cnt, frame_drop_cnt} !== {16'(ok_exp), 16'(drop_exp)}) begin
            failures++;
            $display("FAIL %s_cnt: got ok=%0d drop=%0d, required ok=%0d drop=%0d",
                     name, frame_ok_cnt, frame_drop_cnt, ok_exp, drop_exp);
        end
        checks++;
        if (pl_len !== len_exp) begin
            failures++;
            $display("FAIL %s_len: got %0d, required %0d", name, pl_len, len_exp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d expected beats never appeared", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({pl_valid, pl_sof, pl_eof, pl_data, pl_len, frame_ok_cnt, frame_drop_cnt} !== 59'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b sof=%0b eof=%0b data=%02h len=%0d ok=%0d drop=%0d, required all 0",
                     pl_valid, pl_sof, pl_eof, pl_data, pl_len, frame_ok_cnt, frame_drop_cnt);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame();
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'h001E);
        expect_payload(22);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("good", 16'd22);
    endtask

    task automatic test_filters();
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       make_frame(7, 48'h02_00_00_00_00_01, 16'h0800, 8'h11, 16'h001E);
                1:       make_frame(7, BCAST, 16'h0806, 8'h11, 16'h001E);
                default: make_frame(7, BCAST, 16'h0800, 8'h06, 16'h001E);
            endcase
            send_frame(frm.size());
            idle(4);
            drop_exp++;
            check_state($sformatf("filter%0d", t), 16'd22);
        end
        make_frame(7, mac_local, 16'h0800, 8'h11, 16'h001E);
        expect_payload(22);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("unicast", 16'd22);
    endtask

    task automatic test_preamble();
        make_frame(8, BCAST, 16'h0800, 8'h11, 16'h001E);
        send_frame(frm.size());
        idle(4);
        drop_exp++;
        check_state("pre8", 16'd22);
        make_frame(1, BCAST, 16'h0800, 8'h11, 16'h001E);
        expect_payload(22);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("pre1", 16'd22);
    endtask

    task automatic test_udp_len();
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'd8);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("len8", 16'd0);
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'd9);
        expect_payload(1);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("len9", 16'd1);
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'd7);
        send_frame(frm.size());
        idle(4);
        drop_exp++;
        check_state("len7", 16'd1);
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'd1481);
        send_frame(frm.size());
        idle(4);
        drop_exp++;
        check_state("len_max", 16'd1);
    endtask

    task automatic test_abort_payload();
        beat_t b;
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'h001E);
        for (int i = 0; i < 5; i++) begin
            b = {pay_byte(i), i == 0, 1'b0};
            exp_q.push_back(b);
        end
        b = {8'h00, 1'b0, 1'b1};
        exp_q.push_back(b);
        send_frame(55);
        idle(4);
        drop_exp++;
        check_state("abort", 16'd22);
    endtask

    task automatic test_back_to_back();
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'h001E);
        expect_payload(22);
        expect_payload(22);
        send_frame(frm.size());
        idle(1);
        send_frame(frm.size());
        idle(4);
        ok_exp += 2;
        check_state("b2b", 16'd22);
    endtask

    task automatic test_rxer();
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'h001E);
        for (int i = 0; i < frm.size(); i++) step(frm[i], 1'b1, i == 15);
        idle(4);
        drop_exp++;
        check_state("rxer", 16'd22);
    endtask

    task automatic test_reset_mid();
        beat_t b;
        make_frame(7, BCAST, 16'h0800, 8'h11, 16'h001E);
        for (int i = 0; i < 5; i++) begin
            b = {pay_byte(i), i == 0, 1'b0};
            exp_q.push_back(b);
        end
        send_frame(56);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pl_valid, pl_sof, pl_eof, pl_data, pl_len, frame_ok_cnt, frame_drop_cnt} !== 59'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got valid=%0b data=%02h len=%0d ok=%0d drop=%0d, required all 0",
                     pl_valid, pl_data, pl_len, frame_ok_cnt, frame_drop_cnt);
        end
        ok_exp = 0;
        drop_exp = 0;
        step(frm[56], 1'b1, 1'b0);
        step(frm[57], 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 58; i < frm.size(); i++) step(frm[i], 1'b1, 1'b0);
        idle(4);
        drop_exp++;
        check_state("midreset_tail", 16'd0);
        expect_payload(22);
        send_frame(frm.size());
        idle(4);
        ok_exp++;
        check_state("after_reset", 16'd22);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_filters();
        test_preamble();
        test_udp_len();
        test_abort_payload();
        test_back_to_back();
        test_rxer();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eth_gmii_rx.md
Name: eth_gmii_rx

Overview:
GMII receive-side frame parser on clk_125m. Takes byte stream plus data-valid from the PHY (RGMII-to-GMII conversion happens upstream). Strips preamble/SFD and filters on destination MAC, EtherType 0x0800 (IPv4) and IP protocol 0x11 (UDP). Emits the UDP payload bytes with start/end/error flags and per-frame status counters, and acts as the receive counterpart of the fixed-frame GMII transmit generator.

Parameters:
LOCAL_MAC, 48'h00_11_22_33_44_56, unicast MAC accepted in addition to broadcast FF:FF:FF:FF:FF:FF
MAX_PAYLOAD, 1472, largest UDP payload length accepted, in bytes
CNT_W, 16, width of the frame status counters

Ports:
clk_125m  in  1  system/GMII rx clock, 125 MHz
rst_n  in  1  asynchronous active-low reset
gmii_rx  in  8  received byte
gmii_rxv  in  1  receive data valid
gmii_rxer  in  1  receive error from the PHY
pl_data  out  8  UDP payload byte
pl_valid  out  1  pl_data valid, one byte per cycle
pl_sof  out  1  first payload byte of the frame (qualified by pl_valid)
pl_eof  out  1  last payload byte (qualified by pl_valid)
pl_len  out  16  UDP payload length (UDP length minus 8), held from header parse until the next frame
frame_ok_cnt  out  CNT_W  frames that delivered a complete payload
frame_drop_cnt  out  CNT_W  frames filtered out or aborted

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk_125m. All inputs are synchronous to clk_125m.
- Reset: all outputs are 0 and the FSM is in IDLE.
- Inputs are registered once. Payload output appears 2 cycles after the byte is on gmii_rx.
- FSM states: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN.
- IDLE: on a rising edge of gmii_rxv with byte 0x55, go to PREAMBLE. Any other first byte goes to DRAIN and counts as a drop.
- PREAMBLE: accepts 0x55 repeatedly. After at least 1 and at most 7 0x55 bytes, byte 0xD5 moves to ETH_HDR. Any other byte, or more than 7 0x55 bytes, goes to DRAIN.
- ETH_HDR: 14 bytes held in a byte counter.
  - Destination MAC must equal LOCAL_MAC or all-ones.
  - EtherType must be 0x0800.
  - A mismatch is decided on the failing byte and goes to DRAIN.
- IP_HDR: the first byte must be 0x45 (IHL=5 only; options are rejected).
  - Protocol byte (offset 9) must be 0x11.
  - The IP checksum is not checked.
  - After 20 bytes, go to UDP_HDR.
- UDP_HDR: 8 bytes. Bytes 4–5 form the UDP length L.
  - L < 8 or L-8 > MAX_PAYLOAD goes to DRAIN.
  - Otherwise pl_len = L-8.
  - If L == 8, count OK and go to DRAIN with no payload output.
- PAYLOAD: forwards exactly pl_len bytes.
  - pl_sof is set on the first byte and pl_eof on the last.
  - When both occur on the same byte (length 1), both flags are high together.
  - Trailing Ethernet padding and the FCS are not forwarded; go to DRAIN.
  - frame_ok_cnt increments on the cycle pl_eof is output.
- DRAIN: discards bytes until gmii_rxv is low, then returns to IDLE.
- Aborts: gmii_rxv dropping low, or gmii_rxer high, in any state other than IDLE/DRAIN aborts the frame.
  - In PAYLOAD, one final beat with pl_valid=1, pl_eof=1 and pl_data=0 is emitted as an error marker. This marker is signalled by pl_eof arriving before pl_len bytes.
  - frame_drop_cnt increments once per aborted or filtered frame.
- FSM minimum gap: after gmii_rxv goes low, at least 1 cycle is spent in IDLE. A frame whose gmii_rxv reasserts on the very next cycle is accepted.
- Counters saturate at all-ones; they do not wrap.
- Reset asserted mid-frame clears everything immediately. After reset releases, the remainder of an in-progress frame is seen as not starting with 0x55, so it is dropped via DRAIN.

Optional Feature:
Macro ETH_RX_FCS_CHECK_EN.
- Defined: a CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over the bytes from the destination MAC through the FCS.
  - A residue other than 0xC704DD7B when gmii_rxv falls counts as a drop instead of OK.
  - Payload already streamed has its final pl_eof delayed until the FCS is verified, and the error marker is emitted on failure. Payload is buffered in a 2048-byte FIFO.
- Undefined: no CRC logic or FIFO is built. pl_eof is issued on the last payload byte and the FCS is ignored.

Test Plan:
- Send a 76-byte frame: 7×0x55, 0xD5, dst FF×6, src 00:11:22:33:44:56, 0x0800, IPv4/UDP with UDP length 0x001E. Expect 22 payload bytes (0x16 BF EF ... 0x9C, without FCS checking), pl_len=22, pl_sof on 0x16, pl_eof on the 22nd byte, frame_ok_cnt=1.
- Same frame with destination 02:00:00:00:00:01 → no pl_valid, frame_drop_cnt=1.
- Same frame with EtherType 0x0806 → dropped; with IP protocol 0x06 → dropped; frame_ok_cnt unchanged.
- Drop gmii_rxv after the 5th payload byte → 5 data beats, then an error beat with pl_eof=1 and pl_data=0; frame_drop_cnt+1.
- Send two back-to-back frames with a 1-cycle gap → both delivered, frame_ok_cnt=2. Pulse gmii_rxer mid-header → dropped.
- Assert rst_n low mid-payload → outputs are 0 immediately. Send the next clean frame → accepted normally.
